// File: rtl/y86_writeback.sv
// Y86-64 write-back stage: architectural register file, status machine and
// retired-instruction counter for the sequential core.
module y86_writeback #(
    parameter logic [63:0] RESET_RSP = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic        mem_err,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic [63:0] reg_mem0,
    output logic [63:0] reg_mem1,
    output logic [63:0] reg_mem2,
    output logic [63:0] reg_mem3,
    output logic [63:0] reg_mem4,
    output logic [63:0] reg_mem5,
    output logic [63:0] reg_mem6,
    output logic [63:0] reg_mem7,
    output logic [63:0] reg_mem8,
    output logic [63:0] reg_mem9,
    output logic [63:0] reg_mem10,
    output logic [63:0] reg_mem11,
    output logic [63:0] reg_mem12,
    output logic [63:0] reg_mem13,
    output logic [63:0] reg_mem14,
    output logic [63:0] reg_mem15,
    output logic [2:0]  stat,
    output logic [63:0] retired,
    output logic        wb_done
);

    typedef enum logic [2:0] {
        S_AOK = 3'd1,
        S_HLT = 3'd2,
        S_ADR = 3'd3,
        S_INS = 3'd4
    } stat_t;

    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [3:0] R_RSP  = 4'h4;

    logic [63:0] r_regs [0:14];
    stat_t       r_stat;
    logic [63:0] r_retired;
    logic        r_wb_done;

    logic [3:0]  w_dstE;
    logic [3:0]  w_dstM;
    logic        w_accept;

    always_comb begin
        w_dstE = R_NONE;
        case (icode)
            4'h2:                      w_dstE = cnd ? rB : R_NONE;
            4'h3, 4'h6:                w_dstE = rB;
            4'h8, 4'h9, 4'hA, 4'hB:    w_dstE = R_RSP;
            default:                   w_dstE = R_NONE;
        endcase
    end

    always_comb begin
        w_dstM = R_NONE;
        if (icode == 4'h5 || icode == 4'hB)
            w_dstM = rA;
    end

    assign w_accept = wb_valid && (r_stat == S_AOK);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 15; i++)
                r_regs[i] <= (i == 4) ? RESET_RSP : '0;
            r_stat    <= S_AOK;
            r_retired <= '0;
            r_wb_done <= 1'b0;
        end else begin
            r_wb_done <= w_accept;
            if (w_accept) begin
                if (mem_err) begin
                    r_stat <= S_ADR;
                end else if (icode > 4'hB) begin
                    r_stat <= S_INS;
                end else if (icode == 4'h0) begin
                    r_stat    <= S_HLT;
                    r_retired <= r_retired + 64'd1;
                end else begin
                    // M port wins when both ports target the same register (popq %rsp).
                    for (int unsigned i = 0; i < 15; i++) begin
                        if (w_dstM == 4'(i))
                            r_regs[i] <= valM;
                        else if (w_dstE == 4'(i))
                            r_regs[i] <= valE;
                    end
                    r_retired <= r_retired + 64'd1;
                end
            end
        end
    end

    assign reg_mem0  = r_regs[0];
    assign reg_mem1  = r_regs[1];
    assign reg_mem2  = r_regs[2];
    assign reg_mem3  = r_regs[3];
    assign reg_mem4  = r_regs[4];
    assign reg_mem5  = r_regs[5];
    assign reg_mem6  = r_regs[6];
    assign reg_mem7  = r_regs[7];
    assign reg_mem8  = r_regs[8];
    assign reg_mem9  = r_regs[9];
    assign reg_mem10 = r_regs[10];
    assign reg_mem11 = r_regs[11];
    assign reg_mem12 = r_regs[12];
    assign reg_mem13 = r_regs[13];
    assign reg_mem14 = r_regs[14];
    assign reg_mem15 = '0;

    assign stat    = r_stat;
    assign retired = r_retired;
    assign wb_done = r_wb_done;

endmodule

// File: tb/tb_y86_writeback.sv
// Bench for y86_writeback: directed test-plan steps followed by random
// instruction streams, all checked against a behavioural register-file model.
module tb_y86_writeback;

    localparam logic [63:0] RSP0 = 64'h0000_0000_0000_F000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic [3:0]  icode = '0;
    logic [3:0]  rA = 4'hF;
    logic [3:0]  rB = 4'hF;
    logic        cnd = 1'b0;
    logic        mem_err = 1'b0;
    logic [63:0] valE = '0;
    logic [63:0] valM = '0;
    logic [63:0] rm [16];
    logic [2:0]  stat;
    logic [63:0] retired;
    logic        wb_done;

    int total = 0;
    int bad = 0;

    logic [63:0] m_regs [16];
    int          m_stat;
    logic [63:0] m_ret;
    logic        m_done;

    always #5 clk = ~clk;

    y86_writeback #(.RESET_RSP(RSP0)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode),
        .rA(rA), .rB(rB), .cnd(cnd), .mem_err(mem_err),
        .valE(valE), .valM(valM),
        .reg_mem0(rm[0]),   .reg_mem1(rm[1]),   .reg_mem2(rm[2]),   .reg_mem3(rm[3]),
        .reg_mem4(rm[4]),   .reg_mem5(rm[5]),   .reg_mem6(rm[6]),   .reg_mem7(rm[7]),
        .reg_mem8(rm[8]),   .reg_mem9(rm[9]),   .reg_mem10(rm[10]), .reg_mem11(rm[11]),
        .reg_mem12(rm[12]), .reg_mem13(rm[13]), .reg_mem14(rm[14]), .reg_mem15(rm[15]),
        .stat(stat), .retired(retired), .wb_done(wb_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one clock edge, straight from the ISA rules.
    task automatic model_edge(input logic r, input logic v, input logic [3:0] ic,
                              input logic [3:0] ra, input logic [3:0] rb, input logic c,
                              input logic me, input logic [63:0] ve, input logic [63:0] vm);
        int dE, dM;
        if (r) begin
            foreach (m_regs[k]) m_regs[k] = 64'd0;
            m_regs[4] = RSP0;
            m_stat = 1;
            m_ret = 64'd0;
            m_done = 1'b0;
            return;
        end
        m_done = v && (m_stat == 1);
        if (!m_done) return;
        if (me) m_stat = 3;
        else if (ic > 11) m_stat = 4;
        else if (ic == 0) begin
            m_stat = 2;
            m_ret = m_ret + 64'd1;
        end else begin
            dE = 15;
            dM = 15;
            if (ic == 2) dE = c ? int'(rb) : 15;
            else if (ic == 3 || ic == 6) dE = int'(rb);
            else if (ic >= 8 && ic <= 11) dE = 4;
            if (ic == 5 || ic == 11) dM = int'(ra);
            if (dE != 15) m_regs[dE] = ve;
            if (dM != 15) m_regs[dM] = vm;
            m_ret = m_ret + 64'd1;
        end
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < 16; k++)
            check($sformatf("%s.reg%0d", tag, k), rm[k], m_regs[k]);
        check({tag, ".stat"}, 64'(stat), 64'(m_stat));
        check({tag, ".retired"}, retired, m_ret);
        check({tag, ".wb_done"}, 64'(wb_done), 64'(m_done));
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic [3:0] ic,
                        input logic [3:0] ra, input logic [3:0] rb, input logic c,
                        input logic me, input logic [63:0] ve, input logic [63:0] vm);
        @(negedge clk);
        rst = r; wb_valid = v; icode = ic; rA = ra; rB = rb; cnd = c;
        mem_err = me; valE = ve; valM = vm;
        @(posedge clk);
        model_edge(r, v, ic, ra, rb, c, me, ve, vm);
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [3:0]  ic;
        logic        me, v, r;
        foreach (m_regs[k]) m_regs[k] = 64'd0;
        m_stat = 1; m_ret = 64'd0; m_done = 1'b0;

        step("rst0", 1, 0, 4'h0, 4'hF, 4'hF, 0, 0, 64'd0, 64'd0);
        step("rst1", 1, 0, 4'h0, 4'hF, 4'hF, 0, 0, 64'd0, 64'd0);
        check("rsp_reset", rm[4], 64'h0000_0000_0000_F000);
        step("irmovq", 0, 1, 4'h3, 4'hF, 4'h2, 0, 0, 64'd10, 64'd0);
        check("irmovq_r2", rm[2], 64'd10);
        check("irmovq_ret", retired, 64'd1);
        step("idle", 0, 0, 4'h3, 4'hF, 4'h2, 0, 0, 64'd99, 64'd0);
        check("done_pulse_end", 64'(wb_done), 64'd0);
        step("cmov_n", 0, 1, 4'h2, 4'hF, 4'h3, 0, 0, 64'd5, 64'd0);
        step("cmov_y", 0, 1, 4'h2, 4'hF, 4'h3, 1, 0, 64'd5, 64'd0);
        check("cmov_r3", rm[3], 64'd5);
        step("popq_rsp", 0, 1, 4'hB, 4'h4, 4'hF, 0, 0, 64'h100, 64'h55);
        check("popq_rsp_r4", rm[4], 64'h55);
        step("popq_r1", 0, 1, 4'hB, 4'h1, 4'hF, 0, 0, 64'h108, 64'h7);
        step("mrmovq", 0, 1, 4'h5, 4'h9, 4'h2, 0, 0, 64'h40, 64'hDEAD);
        step("opq", 0, 1, 4'h6, 4'h1, 4'hE, 0, 0, 64'h1234, 64'h0);
        step("nop", 0, 1, 4'h1, 4'hF, 4'hF, 0, 0, 64'h77, 64'h88);
        step("halt", 0, 1, 4'h0, 4'hF, 4'hF, 0, 0, 64'd0, 64'd0);
        check("halt_stat", 64'(stat), 64'd2);
        step("locked", 0, 1, 4'h3, 4'hF, 4'h0, 0, 0, 64'd9, 64'd0);
        step("rst_a", 1, 0, 4'h0, 4'hF, 4'hF, 0, 0, 64'd0, 64'd0);
        step("ins", 0, 1, 4'hC, 4'h1, 4'h2, 0, 0, 64'd3, 64'd4);
        check("ins_stat", 64'(stat), 64'd4);
        step("ins_lock", 0, 1, 4'h3, 4'hF, 4'h1, 0, 0, 64'd3, 64'd4);
        step("rst_b", 1, 0, 4'h0, 4'hF, 4'hF, 0, 0, 64'd0, 64'd0);
        step("adr", 0, 1, 4'h5, 4'h6, 4'hF, 0, 1, 64'd3, 64'hBEEF);
        check("adr_stat", 64'(stat), 64'd3);
        step("rst_c", 1, 0, 4'h0, 4'hF, 4'hF, 0, 0, 64'd0, 64'd0);
        step("irm_pre", 0, 1, 4'h3, 4'hF, 4'h7, 0, 0, 64'd21, 64'd0);
        step("rst_prio", 1, 1, 4'h3, 4'hF, 4'h5, 0, 0, 64'd7, 64'd0);
        check("rst_prio_r5", rm[5], 64'd0);
        check("rst_prio_done", 64'(wb_done), 64'd0);

        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 99) < 3) || (m_stat != 1 && $urandom_range(0, 99) < 30);
            v = $urandom_range(0, 99) < 80;
            if ($urandom_range(0, 99) < 4) ic = 4'h0;
            else if ($urandom_range(0, 99) < 3) ic = 4'($urandom_range(12, 15));
            else ic = 4'($urandom_range(1, 11));
            me = $urandom_range(0, 99) < 3;
            step($sformatf("rnd%0d", n), r, v, ic, 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), me,
                 {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/y86_writeback.md
# y86_writeback

Write-back stage and architectural register file for the sequential Y86-64 processor. Each accepted instruction's `valE`/`valM` results are committed into the fifteen program registers, selected by `icode`, `rA`, `rB` and `cnd`. A processor status machine (AOK/HLT/ADR/INS) and a retired-instruction counter are also kept here. The block sits after execute/memory and is the write-side counterpart of `decode`: `decode` reads the `reg_mem*` values this block drives.

## Interface
Parameters:
- `RESET_RSP`, 64'd0: reset value of register 4 (%rsp). All other registers reset to 0.

Ports:
- Clock is `clk` and reset is `rst`. Reset is synchronous and active-high.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `wb_valid`  in  1  instruction present on the inputs this cycle.
- `icode`  in  4  instruction code.
- `rA`  in  4  register A; 4'hF means none.
- `rB`  in  4  register B; 4'hF means none.
- `cnd`  in  1  condition result from execute; used only by cmovXX.
- `mem_err`  in  1  memory stage reported an invalid address.
- `valE`  in  64  ALU result.
- `valM`  in  64  memory read data.
- `reg_mem0` … `reg_mem14`  out  64 each  architectural registers.
- `reg_mem15`  out  64  constant 0; register F is not storage.
- `stat`  out  3  status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- `retired`  out  64  count of instructions accepted with stat AOK and no error.
- `wb_done`  out  1  one-cycle pulse acknowledging an accepted instruction.

## Operation
Destination select, computed combinationally from the inputs:
- dstE:
  - icode 2 (cmovXX): rB if cnd=1, else F.
  - icode 3 (irmovq) and 6 (OPq): rB.
  - icode 8, 9, A, B (call/ret/pushq/popq): 4.
  - All other icodes: F.
- dstM: rA for icode 5 (mrmovq) and B (popq); F otherwise.

Acceptance rule: an instruction is accepted on an edge where `rst`=0, `wb_valid`=1 and `stat`=AOK. At each accepted edge:
- `mem_err`=1: stat←ADR. No register write, `retired` unchanged.
- Otherwise, icode > 4'hB: stat←INS. No register write, `retired` unchanged.
- Otherwise, icode 0 (halt): stat←HLT, `retired`+1, no register write.
- Otherwise: write `valE` to dstE and `valM` to dstM, `retired`+1.
  - Writes to F are dropped.
  - If dstE == dstM (e.g. popq %rsp), only `valM` is written. The M port has priority.

Status FSM:
- States AOK, HLT, ADR, INS. Transitions out of AOK only, as listed above.
- HLT, ADR and INS are absorbing until `rst`.
- In a non-AOK state, `wb_valid` is ignored: no writes, counter frozen, no `wb_done`.

Counter:
- `retired` wraps modulo 2^64.

Reset:
- All registers ← 0, except reg 4 ← `RESET_RSP`.
- stat←AOK, `retired`←0, `wb_done`←0.
- `rst` has priority over a simultaneous `wb_valid`; that instruction is discarded.

## Timing
- Single-cycle commit. Written values are visible on `reg_mem*` immediately after the accepting edge, so `decode` in the next cycle sees them.
- `wb_done` is registered. It is high for exactly the one cycle following each accepting edge, including edges that produce HLT, ADR or INS.
- Back-to-back `wb_valid` is allowed every cycle. There is no stall or backpressure.
- `stat` and `retired` update on the same edge as the register write.
- `reg_mem*` outputs are direct register outputs with no combinational path from inputs. Decode therefore never observes a same-cycle bypass.
- Reset asserted mid-run takes effect at the next edge regardless of stat.

## Test plan
- Reset, then irmovq: `rst` 1 for 2 cycles, then `wb_valid`=1, icode=3, rB=2, valE=64'd10 → reg_mem2=10 next cycle, `retired`=1, `wb_done` pulses for 1 cycle, all other registers 0, stat=1.
- cmov condition: icode=2, rB=3, valE=5.
  - cnd=0 → reg_mem3 unchanged, `retired`+1.
  - cnd=1 → reg_mem3=5.
- popq %rsp priority: icode=B, rA=4, valE=64'h100, valM=64'h55 → reg_mem4=64'h55.
- popq other register: icode=B, rA=1, valE=64'h108, valM=64'h7 → reg_mem4=64'h108 and reg_mem1=7 on the same edge.
- Halt/INS lockout:
  - icode=0 → stat=2, `retired`+1.
  - Following icode=3, rB=0, valE=9 → ignored: reg_mem0 unchanged, no `wb_done`.
  - After reset, icode=4'hC → stat=4, `retired` unchanged.
  - After reset, mem_err=1 with icode=5 → stat=3, no write.
- Reset priority: `rst`=1 together with `wb_valid`=1, icode=3, rB=5, valE=7 → reg_mem5=0, `retired`=0, stat=1, `wb_done`=0. Also check reg_mem15 reads 0 throughout.
